// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
//
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// A request seen in IDLE with a non-zero slave select starts a transaction.
// One byte is shifted out on mosi while one byte is captured from miso.
// spi_clk runs at clk/2 during the transfer. On completion the received byte
// appears on data_out together with a one-cycle done pulse.
//
// Ports
//   clk       system clock, all state changes on the rising edge
//   rst       asynchronous reset, active low (0 = reset)
//   data_in   byte to transmit, sampled only when a transaction is accepted
//   start     level-sampled request, honoured only in IDLE with cs != 0
//   cs        one-hot slave select (N bits), latched at acceptance
//   spi_clk   registered SPI clock, idle low
//   mosi      registered serial data out, idle low
//   miso      serial data in from the selected slave (no synchronizer)
//   data_out  last received byte, held until the next completion
//   done      one-cycle pulse when data_out is updated
// -----------------------------------------------------------------------------
module spi_master #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   data_in,
    input  logic         start,
    input  logic [N-1:0] cs,
    output logic         spi_clk,
    output logic         mosi,
    input  logic         miso,
    output logic [7:0]   data_out,
    output logic         done
);

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] TRANSFER = 1'b1;

    logic [0:0]   state_reg;
    logic [7:0]   tx_reg;
    logic [7:0]   rx_reg;
    logic [3:0]   bit_cnt_reg;
    logic         phase_reg;      // 0: next edge raises spi_clk, 1: next edge lowers it
    logic [N-1:0] cs_latched_reg;
    logic         spi_clk_reg;
    logic         mosi_reg;
    logic [7:0]   data_out_reg;
    logic         done_reg;

    logic         accept;
    logic         slave_sel;

    assign accept    = start && (cs != '0);
    // Acceptance guarantees a non-zero latched select; losing it mid-transfer
    // can only come from corruption, and then the transfer is dropped quietly.
    assign slave_sel = |cs_latched_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            tx_reg         <= 8'h00;
            rx_reg         <= 8'h00;
            bit_cnt_reg    <= 4'd0;
            phase_reg      <= 1'b0;
            cs_latched_reg <= '0;
            spi_clk_reg    <= 1'b0;
            mosi_reg       <= 1'b0;
            data_out_reg   <= 8'h00;
            done_reg       <= 1'b0;
        end else begin
            // done is asserted only on the completing edge, so it self-clears.
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg      <= TRANSFER;
                        tx_reg         <= data_in;
                        mosi_reg       <= data_in[7];
                        bit_cnt_reg    <= 4'd0;
                        phase_reg      <= 1'b0;
                        cs_latched_reg <= cs;
                        spi_clk_reg    <= 1'b0;
                    end
                end
                TRANSFER: begin
                    if (!slave_sel) begin
                        state_reg   <= IDLE;
                        spi_clk_reg <= 1'b0;
                        mosi_reg    <= 1'b0;
                    end else if (!phase_reg) begin
                        // Rising SPI edge: sample miso, MSB arrives first.
                        spi_clk_reg <= 1'b1;
                        rx_reg      <= {rx_reg[6:0], miso};
                        bit_cnt_reg <= bit_cnt_reg + 4'd1;
                        phase_reg   <= 1'b1;
                    end else begin
                        // Falling SPI edge: present the next bit a full clk
                        // period ahead of the following rising edge.
                        spi_clk_reg <= 1'b0;
                        phase_reg   <= 1'b0;
                        if (bit_cnt_reg == 4'd8) begin
                            mosi_reg     <= 1'b0;
                            data_out_reg <= rx_reg;
                            done_reg     <= 1'b1;
                            state_reg    <= IDLE;
                        end else begin
                            tx_reg   <= {tx_reg[6:0], 1'b0};
                            mosi_reg <= tx_reg[6];
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign spi_clk  = spi_clk_reg;
    assign mosi     = mosi_reg;
    assign data_out = data_out_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
//
// Drives spi_master with directed and random byte transfers. The reference
// model is the serial protocol itself: after acceptance edge k, spi_clk is
// high on odd k, mosi carries data bit 7-floor(k/2), miso bit 7-i is sampled
// at edge 2i+1, and edge 16 delivers the miso byte with a done pulse.
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic [7:0]   data_in;
    logic         start;
    logic [N-1:0] cs;
    logic         spi_clk;
    logic         mosi;
    logic         miso;
    logic [7:0]   data_out;
    logic         done;

    int n_cmp;
    int n_err;
    int done_seen;          // done pulses observed on the bus
    int done_expected;      // done pulses the model predicts
    logic [7:0] model_rx;   // model of data_out

    spi_master #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .start    (start),
        .cs       (cs),
        .spi_clk  (spi_clk),
        .mosi     (mosi),
        .miso     (miso),
        .data_out (data_out),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) done_seen++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, " spi_clk"},  {31'd0, spi_clk}, 32'd0);
        check_val({tag, " mosi"},     {31'd0, mosi},    32'd0);
        check_val({tag, " done"},     {31'd0, done},    32'd0);
        check_val({tag, " data_out"}, {24'd0, data_out}, {24'd0, model_rx});
    endtask

    // One transaction. repulse: edge at which start is re-asserted with other
    // data/cs (0 = never). pre_armed: start was left high by the previous
    // transfer. chain_out: leave start high with next_data for back-to-back.
    task automatic run_xfer(input logic [7:0] d, input logic [N-1:0] c, input logic [7:0] mb,
                            input int repulse, input bit pre_armed, input bit chain_out,
                            input logic [7:0] next_data);
        logic [7:0] exp_out;
        int pulses;
        if (!pre_armed) begin
            data_in = d;
            cs      = c;
            start   = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check_val("e0 spi_clk", {31'd0, spi_clk}, 32'd0);
        check_val("e0 mosi",    {31'd0, mosi},    {31'd0, d[7]});
        check_val("e0 done",    {31'd0, done},    32'd0);
        pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k % 2 == 1) miso = mb[7 - (k - 1) / 2];
            if (repulse != 0 && k == repulse) begin
                start   = 1'b1;
                data_in = ~d;
                cs      = ~c;
            end
            if (repulse != 0 && k == repulse + 1) start = 1'b0;
            if (chain_out && k == 16) begin
                start   = 1'b1;
                data_in = next_data;
                cs      = c;
            end
            @(posedge clk); #1;
            if (spi_clk === 1'b1) pulses++;
            check_val($sformatf("e%0d spi_clk", k), {31'd0, spi_clk}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check_val($sformatf("e%0d mosi", k), {31'd0, mosi},
                      (k == 16) ? 32'd0 : {31'd0, d[7 - k / 2]});
            check_val($sformatf("e%0d done", k), {31'd0, done}, (k == 16) ? 32'd1 : 32'd0);
            exp_out = (k == 16) ? mb : model_rx;
            check_val($sformatf("e%0d data_out", k), {24'd0, data_out}, {24'd0, exp_out});
        end
        check_val("spi_clk pulses", pulses, 32'd8);
        model_rx = mb;
        done_expected++;
        if (!chain_out) begin
            @(posedge clk); #1;
            check_idle_outputs("e17");
        end
        $display("xfer tx=%02h cs=%b miso=%02h data_out=%02h repulse=%0d chained=%0d",
                 d, c, mb, data_out, repulse, chain_out);
    endtask

    initial begin
        logic [7:0] d, mb;
        logic [N-1:0] c;
        n_cmp = 0; n_err = 0; done_seen = 0; done_expected = 0;
        model_rx = 8'h00;
        rst = 1'b0; start = 1'b0; data_in = 8'h00; cs = '0; miso = 1'b0;
        #2;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post-reset");

        // Directed cases.
        run_xfer(8'hA5, 4'b0010, 8'h3C, 0, 1'b0, 1'b0, 8'h00);
        run_xfer(8'h96, 4'b0001, 8'h55, 0, 1'b0, 1'b0, 8'h00);
        run_xfer(8'h0F, 4'b1000, 8'hFF, 0, 1'b0, 1'b0, 8'h00);
        run_xfer(8'hC3, 4'b0100, 8'h81, 6, 1'b0, 1'b0, 8'h00);

        // cs == 0 must block acceptance entirely.
        data_in = 8'h5A; cs = '0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check_idle_outputs($sformatf("cs0 c%0d", i));
        end
        start = 1'b0;
        $display("xfer cs=0 request held 20 cycles, data_out=%02h", data_out);

        // Back-to-back: start held high through completion.
        run_xfer(8'h3E, 4'b0010, 8'h71, 0, 1'b0, 1'b1, 8'hD4);
        run_xfer(8'hD4, 4'b0010, 8'h2B, 0, 1'b1, 1'b0, 8'h00);

        // Reset asserted after edge 9 of a transfer.
        data_in = 8'hE7; cs = 4'b0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            miso = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        #1;
        rst = 1'b0;
        model_rx = 8'h00;
        #1;
        check_idle_outputs("abort async");
        @(posedge clk); #1;
        check_idle_outputs("abort held");
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        check_idle_outputs("abort after");
        check_val("abort done count", done_seen, done_expected);
        $display("xfer aborted by reset at edge 9, data_out=%02h", data_out);
        run_xfer(8'h69, 4'b1000, 8'hB2, 0, 1'b0, 1'b0, 8'h00);

        // Random traffic.
        for (int t = 0; t < 12; t++) begin
            d  = 8'($urandom);
            mb = 8'($urandom);
            c  = N'(1) << $urandom_range(0, N - 1);
            run_xfer(d, c, mb, (t % 3 == 0) ? int'($urandom_range(1, 15)) : 0, 1'b0, 1'b0, 8'h00);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) @(posedge clk);
            #1;
        end

        check_val("total done pulses", done_seen, done_expected);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
